corr_peak_detect: RTL and testbench
===================================

// Module: corr_peak_detect
// PURPOSE
//  Downstream stage of the FFT/IFFT correlator. Consumes the compressed IFFT output
//  (separate M_AXIS_RE/M_AXIS_IM streams, one complex sample per beat, 1024-sample frames).
//  Computes |x|^2 = re^2 + im^2 per sample and tracks the frame maximum and its index.
//  Emits one peak report per frame on an AXI-Stream master, with a threshold-detect flag.
// PARAMETERS
//  DATA_W     16    signed width of RE/IM samples (two's complement)
//  FRAME_LEN  1024  expected samples per frame; min 4
//  IDX_W      10    index width, = clog2(FRAME_LEN)
// PORTS
//  aclk              in   1         clock, all logic on rising edge
//  areset            in   1         synchronous reset, active-high
//  S_AXIS_RE_tdata   in   DATA_W    real part, signed
//  S_AXIS_RE_tvalid  in   1         RE beat valid
//  S_AXIS_RE_tlast   in   1         last sample of frame
//  S_AXIS_RE_tready  out  1         RE beat accepted when tvalid&tready
//  S_AXIS_IM_tdata   in   DATA_W    imag part, signed
//  S_AXIS_IM_tvalid  in   1         IM beat valid
//  S_AXIS_IM_tready  out  1         IM beat accepted when tvalid&tready
//  cfg_threshold     in   2*DATA_W  detect threshold on |x|^2, sampled at first beat of frame
//  M_AXIS_PEAK_tdata out  64        [31:0] peak |x|^2, [47:32] index (zero-ext), [48] detect, [49] len_err, [63:50] 0
//  M_AXIS_PEAK_tvalid out 1         peak report valid
//  M_AXIS_PEAK_tready in  1         downstream ready
// BEHAVIOUR
//  - Reset: FSM=IDLE, counter=0, max=0, idx=0, pipeline valids=0, both S_*_tready=0 during reset,
//    M_AXIS_PEAK_tvalid=0, M_AXIS_PEAK_tdata=0. Reset mid-frame discards partial frame, no report.
//  - Join: beat accepted only when RE_tvalid & IM_tvalid & acc_en; both tready = acc_en & other tvalid
//    (never accept one lane without the other). acc_en = state in {IDLE, ACC}. RE_tlast used; IM has no tlast.
//  - Pipeline (3 cycles): P1 register re,im; P2 sq_re=re*re, sq_im=im*im (signed mult, unsigned result);
//    P3 mag = sq_re+sq_im, 2*DATA_W bits unsigned, no saturation (max 2*2^30 = 0x8000_0000 fits).
//  - Compare in P3: if mag > max (strict) then max<=mag, idx<=sample index; ties keep earliest index.
//    Index 0 always loads (max cleared at frame start, then first sample loads unconditionally).
//  - FSM: IDLE  -first beat accepted-> ACC (latch cfg_threshold, cnt=1; if that beat is end -> FLUSH)
//         ACC   -end beat accepted-> FLUSH; end = tlast OR cnt==FRAME_LEN-1
//         FLUSH -3 cycles, pipeline drained-> HOLD; input tready=0
//         HOLD  M_AXIS_PEAK_tvalid=1; tdata stable; -tvalid&tready-> IDLE (max, cnt cleared)
//  - len_err=1 if tlast seen with cnt!=FRAME_LEN-1, or cnt reaches FRAME_LEN-1 with tlast=0
//    (frame still closed by counter; subsequent beats start a new frame).
//  - detect = (peak >= latched threshold).
//  - Latency: last accepted beat -> M_AXIS_PEAK_tvalid high 4 cycles later. Input stalled from
//    end beat until report accepted; next frame accepted the cycle after IDLE re-entry.
//  - Input tdata/tvalid ignored while tready=0. Output holds under backpressure indefinitely.
// TESTING
//  1 Impulse: re=1000,im=0 at index 37, rest 0, tlast@1023 -> mag=1_000_000, idx=37, err=0.
//  2 Ties: |x|^2=5000 at idx 5 and 900, rest smaller -> idx=5.
//  3 Full scale: re=im=-32768 at idx 1023 -> mag=0x8000_0000, idx=1023, no wrap.
//  4 Short frame: tlast at idx 99, peak at 50 -> idx=50, len_err=1; missing tlast@1023 -> len_err=1.
//  5 Backpressure: M_tready=0 for 20 cycles in HOLD -> tdata stable, S_*_tready=0, no beat lost;
//    RE_tvalid without IM_tvalid -> no accept, cnt unchanged.
//  6 areset mid-frame at idx 500 -> outputs 0, next full frame reports only its own peak;
//    threshold 1_000_000 vs peak 999_999 -> detect=0; peak 1_000_000 -> detect=1.

Source files
------------

// File: rtl/corr_peak_detect.sv
// Peak |x|^2 tracker for the correlator IFFT output: joins the RE/IM lanes,
// squares each sample, finds the frame maximum and its index, and emits one report per frame.
//
// Ports
//   aclk, areset        clock; synchronous active-high reset
//   S_AXIS_RE_*         real lane: tdata, tvalid, tlast, tready
//   S_AXIS_IM_*         imaginary lane: tdata, tvalid, tready (no tlast)
//   cfg_threshold       detect threshold, captured on the first beat of each frame
//   M_AXIS_PEAK_*       64-bit report
//                         [31:0]  peak |x|^2
//                         [47:32] peak index
//                         [48]    detect
//                         [49]    len_err
module corr_peak_detect #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1024,
  parameter int IDX_W     = 10
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic signed [DATA_W-1:0]   S_AXIS_RE_tdata,
  input  logic                       S_AXIS_RE_tvalid,
  input  logic                       S_AXIS_RE_tlast,
  output logic                       S_AXIS_RE_tready,
  input  logic signed [DATA_W-1:0]   S_AXIS_IM_tdata,
  input  logic                       S_AXIS_IM_tvalid,
  output logic                       S_AXIS_IM_tready,
  input  logic [2*DATA_W-1:0]        cfg_threshold,
  output logic [63:0]                M_AXIS_PEAK_tdata,
  output logic                       M_AXIS_PEAK_tvalid,
  input  logic                       M_AXIS_PEAK_tready
);

  localparam int MAG_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE, ACC, FLUSH, HOLD
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] cnt_q;
  logic [MAG_W-1:0] thr_q;
  logic             err_q;
  logic [MAG_W-1:0] max_q;
  logic [IDX_W-1:0] idx_q;

  logic                     p1_v, p2_v, p3_v;
  logic signed [DATA_W-1:0] p1_re, p1_im;
  logic [IDX_W-1:0]         p1_idx, p2_idx, p3_idx;
  logic [MAG_W-1:0]         p2_sq_re, p2_sq_im, p3_mag;

  logic signed [MAG_W-1:0]  re_ext, im_ext;
  logic signed [MAG_W-1:0]  prod_re, prod_im;

  logic acc_en, beat, at_last, end_beat, len_bad;
  logic drained, rep_done;

  // Lanes are joined: neither side is taken without the other.
  assign acc_en  = !areset && (state_q == IDLE || state_q == ACC);
  assign S_AXIS_RE_tready = acc_en & S_AXIS_IM_tvalid;
  assign S_AXIS_IM_tready = acc_en & S_AXIS_RE_tvalid;
  assign beat    = acc_en & S_AXIS_RE_tvalid & S_AXIS_IM_tvalid;

  // A frame closes on tlast or on the counter, whichever comes first.
  assign at_last  = (cnt_q == LAST_IDX);
  assign end_beat = beat & (S_AXIS_RE_tlast | at_last);
  assign len_bad  = S_AXIS_RE_tlast ^ at_last;

  assign re_ext  = MAG_W'(p1_re);
  assign im_ext  = MAG_W'(p1_im);
  assign prod_re = re_ext * re_ext;
  assign prod_im = im_ext * im_ext;

  assign drained  = !p1_v && !p2_v && !p3_v;
  assign rep_done = (state_q == HOLD) && M_AXIS_PEAK_tready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (beat) state_d = end_beat ? FLUSH : ACC;
      ACC:   if (end_beat) state_d = FLUSH;
      FLUSH: if (drained) state_d = HOLD;
      HOLD:  if (M_AXIS_PEAK_tready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      thr_q    <= '0;
      err_q    <= 1'b0;
      max_q    <= '0;
      idx_q    <= '0;
      p1_v     <= 1'b0;
      p2_v     <= 1'b0;
      p3_v     <= 1'b0;
      p1_re    <= '0;
      p1_im    <= '0;
      p1_idx   <= '0;
      p2_sq_re <= '0;
      p2_sq_im <= '0;
      p2_idx   <= '0;
      p3_mag   <= '0;
      p3_idx   <= '0;
    end else begin
      state_q <= state_d;

      if (beat) cnt_q <= end_beat ? '0 : cnt_q + IDX_W'(1);
      if (beat && state_q == IDLE) thr_q <= cfg_threshold;
      if (end_beat) err_q <= len_bad;

      p1_v   <= beat;
      p1_re  <= S_AXIS_RE_tdata;
      p1_im  <= S_AXIS_IM_tdata;
      p1_idx <= cnt_q;

      p2_v     <= p1_v;
      p2_sq_re <= $unsigned(prod_re);
      p2_sq_im <= $unsigned(prod_im);
      p2_idx   <= p1_idx;

      // Worst case is 2 * 2^30, which still fits unsigned in MAG_W.
      p3_v   <= p2_v;
      p3_mag <= p2_sq_re + p2_sq_im;
      p3_idx <= p2_idx;

      // Strict compare keeps the earliest index on ties.
      if (p3_v && (p3_idx == '0 || p3_mag > max_q)) begin
        max_q <= p3_mag;
        idx_q <= p3_idx;
      end

      if (rep_done) begin
        max_q <= '0;
        idx_q <= '0;
        cnt_q <= '0;
        err_q <= 1'b0;
      end
    end
  end

  assign M_AXIS_PEAK_tvalid = (state_q == HOLD);

  always_comb begin
    M_AXIS_PEAK_tdata = '0;
    if (state_q == HOLD) begin
      M_AXIS_PEAK_tdata[MAG_W-1:0]  = max_q;
      M_AXIS_PEAK_tdata[32 +: IDX_W] = idx_q;
      M_AXIS_PEAK_tdata[48]         = (max_q >= thr_q);
      M_AXIS_PEAK_tdata[49]         = err_q;
    end
  end

endmodule

// File: tb/tb_corr_peak_detect.sv
// Directed bench for corr_peak_detect.
// Drives whole frames, checks each report's latency, fields and handshake behaviour.
module tb_corr_peak_detect;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] re_tdata, im_tdata;
  logic        re_tvalid, re_tlast, re_tready;
  logic        im_tvalid, im_tready;
  logic [31:0] cfg_threshold;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tready;

  int checks = 0;
  int errors = 0;

  logic [15:0] re_v [1024];
  logic [15:0] im_v [1024];

  always #5 aclk = ~aclk;

  corr_peak_detect dut (
    .aclk               (aclk),
    .areset             (areset),
    .S_AXIS_RE_tdata    (re_tdata),
    .S_AXIS_RE_tvalid   (re_tvalid),
    .S_AXIS_RE_tlast    (re_tlast),
    .S_AXIS_RE_tready   (re_tready),
    .S_AXIS_IM_tdata    (im_tdata),
    .S_AXIS_IM_tvalid   (im_tvalid),
    .S_AXIS_IM_tready   (im_tready),
    .cfg_threshold      (cfg_threshold),
    .M_AXIS_PEAK_tdata  (m_tdata),
    .M_AXIS_PEAK_tvalid (m_tvalid),
    .M_AXIS_PEAK_tready (m_tready)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] rep(input logic [31:0] pk, input int ix,
                                      input logic det, input logic err);
    logic [15:0] i16;
    i16 = ix[15:0];
    return {14'd0, err, det, i16, pk};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 1024; i++) begin
      re_v[i] = '0;
      im_v[i] = '0;
    end
  endtask

  task automatic send_beat(input logic [15:0] r, input logic [15:0] i,
                           input logic l);
    int w;
    re_tdata  = r;
    im_tdata  = i;
    re_tlast  = l;
    re_tvalid = 1'b1;
    im_tvalid = 1'b1;
    #1;
    w = 0;
    while (!(re_tready && im_tready) && w < 300) begin
      @(negedge aclk);
      #1;
      w++;
    end
    if (w >= 300) begin
      checks++;
      errors++;
      $error("FAIL beat_timeout observed %0d expected <300", w);
    end
    @(negedge aclk);
  endtask

  task automatic send_frame(input int n, input int last_at,
                            input logic [31:0] thr0, input logic [31:0] thr1);
    cfg_threshold = thr0;
    for (int k = 0; k < n; k++) begin
      send_beat(re_v[k], im_v[k], k == last_at);
      if (k == 0) cfg_threshold = thr1;
    end
    re_tvalid = 1'b0;
    im_tvalid = 1'b0;
    re_tlast  = 1'b0;
  endtask

  task automatic get_report(input string tag, input logic [63:0] exp,
                            input int stall);
    int k;
    k = 0;
    while (!m_tvalid && k < 50) begin
      @(negedge aclk);
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'd4);
    chk({tag, "_data"}, m_tdata, exp);
    if (stall > 0) begin
      re_tdata  = 16'h7fff;
      im_tdata  = 16'h7fff;
      re_tvalid = 1'b1;
      im_tvalid = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge aclk);
        chk({tag, "_hold_data"}, m_tdata, exp);
        chk({tag, "_hold_valid"}, 64'(m_tvalid), 64'd1);
        chk({tag, "_hold_rdy"}, 64'({re_tready, im_tready}), 64'd0);
      end
      re_tvalid = 1'b0;
      im_tvalid = 1'b0;
    end
    m_tready = 1'b1;
    @(negedge aclk);
    m_tready = 1'b0;
    chk({tag, "_done"}, 64'(m_tvalid), 64'd0);
  endtask

  initial begin
    areset        = 1'b1;
    re_tdata      = '0;
    im_tdata      = '0;
    re_tvalid     = 1'b1;
    im_tvalid     = 1'b1;
    re_tlast      = 1'b0;
    cfg_threshold = '0;
    m_tready      = 1'b0;

    repeat (3) @(negedge aclk);
    chk("rst_rdy", 64'({re_tready, im_tready}), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    areset    = 1'b0;
    re_tvalid = 1'b0;
    im_tvalid = 1'b0;
    @(negedge aclk);

    clr();
    re_v[37] = 16'd1000;
    send_frame(1024, 1023, 32'd1_000_000, 32'hffff_ffff);
    get_report("impulse", rep(32'd1_000_000, 37, 1'b1, 1'b0), 0);

    for (int i = 0; i < 1024; i++) begin
      re_v[i] = 16'd1;
      im_v[i] = 16'd1;
    end
    re_v[5]   = 16'd50;
    im_v[5]   = 16'd50;
    re_v[900] = 16'd50;
    im_v[900] = 16'd50;
    send_frame(1024, 1023, 32'd6000, 32'd0);
    get_report("ties", rep(32'd5000, 5, 1'b0, 1'b0), 0);

    clr();
    re_v[1023] = 16'h8000;
    im_v[1023] = 16'h8000;
    send_frame(1024, 1023, 32'hffff_ffff, 32'd0);
    get_report("fullscale", rep(32'h8000_0000, 1023, 1'b0, 1'b0), 0);

    clr();
    re_v[50] = 16'd300;
    send_frame(100, 99, 32'd90000, 32'd0);
    get_report("short", rep(32'd90000, 50, 1'b1, 1'b1), 0);

    clr();
    re_v[600] = 16'd7;
    im_v[600] = 16'hfffd;
    send_frame(1024, -1, 32'd100, 32'd100);
    get_report("notlast", rep(32'd58, 600, 1'b0, 1'b1), 20);

    re_tdata  = 16'h7fff;
    re_tvalid = 1'b1;
    im_tvalid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge aclk);
      chk("re_only_re_rdy", 64'(re_tready), 64'd0);
      chk("re_only_im_rdy", 64'(im_tready), 64'd1);
    end
    re_tvalid = 1'b0;
    @(negedge aclk);

    clr();
    re_v[10] = 16'd20000;
    send_frame(500, -1, 32'd0, 32'd0);
    areset    = 1'b1;
    re_tvalid = 1'b1;
    im_tvalid = 1'b1;
    repeat (2) @(negedge aclk);
    chk("midrst_rdy", 64'({re_tready, im_tready}), 64'd0);
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_tdata", m_tdata, 64'd0);
    areset    = 1'b0;
    re_tvalid = 1'b0;
    im_tvalid = 1'b0;
    repeat (10) @(negedge aclk);
    chk("midrst_noreport", 64'(m_tvalid), 64'd0);

    clr();
    im_v[200] = 16'd1000;
    send_frame(1024, 1023, 32'd1_000_001, 32'd0);
    get_report("afterrst", rep(32'd1_000_000, 200, 1'b0, 1'b0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
